tiny_alu_arbiter: RTL

Shares one tiny_alu between NUM_REQ independent requesters. Each requester has a valid/ready request channel. A round-robin arbiter grants one request at a time and drives the ALU start/opcode/operand bus, holding start until done. The block returns the result, tagged with the requester ID, on a single valid/ready response channel. It sits between the requesters (testbench agents or upstream blocks) and the tiny_alu bus.

---
 rtl/tiny_alu_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/tiny_alu_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tiny_alu_pkg.sv
// Shared opcode, state and helper definitions for the tiny ALU arbiter.
// Used by the round-robin arbiter and its top level.
package tiny_alu_pkg;

  localparam int OPCODE_BITS = 3;

  typedef enum logic [OPCODE_BITS-1:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_op(
    input logic [OPCODE_BITS-1:0] op
  );
    return op <= MUL;
  endfunction

  function automatic logic is_alu_op(
    input logic [OPCODE_BITS-1:0] op
  );
    return is_legal_op(op) && (op != NO_OP);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] k;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/tiny_alu_arbiter.sv
// Shares one tiny_alu between NUM_REQ requesters with round-robin
// arbitration, a done timeout and a tagged response channel.
module tiny_alu_arbiter
  import tiny_alu_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int INPUT_DATA_BITS = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*OPCODE_BITS-1:0]     req_opcode_i,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_a_i,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_b_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]         rsp_id_o,
  output logic [2*INPUT_DATA_BITS-1:0]       rsp_result_o,
  output logic                               rsp_error_o,
  output logic                               alu_start_o,
  output logic [OPCODE_BITS-1:0]             alu_opcode_o,
  output logic [INPUT_DATA_BITS-1:0]         alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]         alu_b_o,
  input  logic                               alu_done_i,
  input  logic [2*INPUT_DATA_BITS-1:0]       alu_result_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int DW = INPUT_DATA_BITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e state_q, state_d;

  logic [IW-1:0]          ptr_q, id_q, ptr_nxt;
  logic [OPCODE_BITS-1:0] op_q;
  logic [DW-1:0]          a_q, b_q;
  logic [2*DW-1:0]        res_q;
  logic                   err_q;
  logic [TW-1:0]          cnt_q;
  logic                   tmo;

  logic [OPCODE_BITS-1:0] op_arr [NUM_REQ];
  logic [DW-1:0]          a_arr  [NUM_REQ];
  logic [DW-1:0]          b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]     win_gnt;
  logic [IW-1:0]          win_idx;
  logic [OPCODE_BITS-1:0] win_op;
  logic [DW-1:0]          win_a, win_b;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_opcode_i[g*OPCODE_BITS +: OPCODE_BITS];
    assign a_arr[g]  = req_a_i[g*DW +: DW];
    assign b_arr[g]  = req_b_i[g*DW +: DW];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_valid_i),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign win_op  = op_arr[win_idx];
  assign win_a   = a_arr[win_idx];
  assign win_b   = b_arr[win_idx];
  assign tmo     = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign ptr_nxt = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + IW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    alu_start_o  = 1'b0;
    alu_opcode_o = '0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = '0;
    rsp_result_o = '0;
    rsp_error_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst_i) req_ready_o = win_gnt;
        if (!rst_i && |req_valid_i)
          state_d = is_alu_op(win_op) ? BUSY : RESP;
      end
      BUSY: begin
        alu_start_o  = 1'b1;
        alu_opcode_o = op_q;
        alu_a_o      = a_q;
        alu_b_o      = b_q;
        if (alu_done_i || tmo) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o  = 1'b1;
        rsp_id_o     = id_q;
        rsp_result_o = res_q;
        rsp_error_o  = err_q;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A done on the timeout cycle still wins over the error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      id_q  <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            id_q  <= win_idx;
            op_q  <= win_op;
            a_q   <= win_a;
            b_q   <= win_b;
            res_q <= '0;
            err_q <= !is_legal_op(win_op);
            cnt_q <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + TW'(1);
          if (alu_done_i)  res_q <= alu_result_i;
          else if (tmo)    err_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready_i) ptr_q <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
